// File: rtl/servo_pkg.sv
// servo_pkg: shared angle width plus pulse-width and clamp helpers for the servo PWM generator
package servo_pkg;
    localparam int ANG_W = 8;

    function automatic int pw_of_angle(input logic [ANG_W-1:0] angle, input int min_us, input int us_per_deg);
        return min_us + int'(angle) * us_per_deg;
    endfunction

    function automatic logic [ANG_W-1:0] clamp_angle(input logic [ANG_W-1:0] angle, input logic [ANG_W-1:0] max_angle);
        return angle > max_angle ? max_angle : angle;
    endfunction
endpackage

// File: rtl/servo_ramp_ch.sv
// servo_ramp_ch: one channel's target/current angle, per-frame ramp, shadowed pulse width and PWM comparator
module servo_ramp_ch
    import servo_pkg::*;
#(
    parameter int PW_W         = 15,
    parameter int MIN_PULSE_US = 500,
    parameter int US_PER_DEG   = 11,
    parameter int MAX_ANGLE    = 180,
    parameter int INIT_ANGLE   = 90,
    parameter int RAMP_STEP    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_run,
    input  logic             i_frame_start,
    input  logic [PW_W-1:0]  i_frame_us,
    input  logic             i_wr,
    input  logic [ANG_W-1:0] i_angle,
    output logic             o_busy,
    output logic             o_pwm
);
    localparam logic [ANG_W-1:0] STEP = ANG_W'(RAMP_STEP);
    localparam logic [ANG_W-1:0] INIT = ANG_W'(INIT_ANGLE);

    logic [ANG_W-1:0] r_tgt, r_cur, w_tgt_d, w_cur_d, w_step;
    logic [PW_W-1:0]  r_pw, w_pw_d;
    logic             r_busy, r_pwm;

    // ramp reads the pre-write target, so a write on the frame_start cycle waits a frame
    always_comb begin
        w_step  = RAMP_STEP == 0 ? r_tgt :
                  r_cur < r_tgt ? (r_tgt - r_cur > STEP ? r_cur + STEP : r_tgt) :
                  (r_cur - r_tgt > STEP ? r_cur - STEP : r_tgt);
        w_cur_d = i_frame_start ? w_step : r_cur;
        w_tgt_d = i_wr ? clamp_angle(i_angle, ANG_W'(MAX_ANGLE)) : r_tgt;
        w_pw_d  = i_frame_start ? PW_W'(pw_of_angle(w_step, MIN_PULSE_US, US_PER_DEG)) : r_pw;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tgt  <= INIT;
            r_cur  <= INIT;
            r_pw   <= PW_W'(pw_of_angle(INIT, MIN_PULSE_US, US_PER_DEG));
            r_busy <= 1'b0;
            r_pwm  <= 1'b0;
        end else begin
            r_tgt  <= w_tgt_d;
            r_cur  <= w_cur_d;
            r_pw   <= w_pw_d;
            r_busy <= w_cur_d != w_tgt_d;
            r_pwm  <= i_run && (i_frame_us < w_pw_d);
        end
    end

    assign o_busy = r_busy;
    assign o_pwm  = r_pwm;
endmodule

// File: rtl/servo_pwm_multi.sv
// servo_pwm_multi: shared microsecond/frame timebase and write decode driving CH_NUM ramped servo channels
module servo_pwm_multi
    import servo_pkg::*;
#(
    parameter int CLK_FRE      = 12_000_000,
    parameter int PWM_CYCLE_MS = 20,
    parameter int CH_NUM       = 4,
    parameter int MIN_PULSE_US = 500,
    parameter int US_PER_DEG   = 11,
    parameter int MAX_ANGLE    = 180,
    parameter int INIT_ANGLE   = 90,
    parameter int RAMP_STEP    = 2
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     cfg_valid,
    output logic                                     cfg_ready,
    input  logic [(CH_NUM > 1 ? $clog2(CH_NUM) : 1)-1:0] cfg_ch,
    input  logic [ANG_W-1:0]                         cfg_angle,
    output logic                                     frame_start,
    output logic [CH_NUM-1:0]                        busy,
    output logic [CH_NUM-1:0]                        pwm
);
    localparam int US_TICKS = CLK_FRE / 1_000_000;
    localparam int FRAME_US = PWM_CYCLE_MS * 1000;
    localparam int PW_W     = $clog2(FRAME_US);
    localparam int UC_W     = US_TICKS > 1 ? $clog2(US_TICKS) : 1;
    localparam int CH_W     = CH_NUM > 1 ? $clog2(CH_NUM) : 1;

    if (longint'(MIN_PULSE_US) + longint'(MAX_ANGLE) * longint'(US_PER_DEG) >= longint'(FRAME_US)) begin : g_err_pw
        $error("servo_pwm_multi: longest pulse does not fit in the frame");
    end
    if (CLK_FRE < 1_000_000 || CLK_FRE % 1_000_000 != 0) begin : g_err_clk
        $error("servo_pwm_multi: CLK_FRE must be a non-zero multiple of 1 MHz");
    end
    if (CH_NUM < 1 || CH_NUM > 16 || MAX_ANGLE > 255 || INIT_ANGLE > MAX_ANGLE || RAMP_STEP > 255) begin : g_err_rng
        $error("servo_pwm_multi: parameter out of range");
    end

    logic [UC_W-1:0]   r_us_cnt, w_us_cnt_d;
    logic [PW_W-1:0]   r_frame_us, w_frame_us_d;
    logic              r_ready, r_frame_start, w_us_tick;
    logic [CH_NUM-1:0] w_wr;

    // counters hold at zero for the first cycle after reset so frame_start lands on (0,0)
    always_comb begin
        w_us_tick    = r_us_cnt == UC_W'(US_TICKS - 1);
        w_us_cnt_d   = !r_ready || w_us_tick ? '0 : r_us_cnt + 1'b1;
        w_frame_us_d = !r_ready ? '0 :
                       !w_us_tick ? r_frame_us :
                       r_frame_us == PW_W'(FRAME_US - 1) ? '0 : r_frame_us + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_us_cnt      <= '0;
            r_frame_us    <= '0;
            r_ready       <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_us_cnt      <= w_us_cnt_d;
            r_frame_us    <= w_frame_us_d;
            r_ready       <= 1'b1;
            r_frame_start <= w_us_cnt_d == '0 && w_frame_us_d == '0;
        end
    end

    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        assign w_wr[i] = cfg_valid && r_ready && cfg_ch == CH_W'(i);
        servo_ramp_ch #(
            .PW_W(PW_W), .MIN_PULSE_US(MIN_PULSE_US), .US_PER_DEG(US_PER_DEG),
            .MAX_ANGLE(MAX_ANGLE), .INIT_ANGLE(INIT_ANGLE), .RAMP_STEP(RAMP_STEP)
        ) u_ch (
            .clk(clk), .rst(rst), .i_run(r_ready), .i_frame_start(r_frame_start),
            .i_frame_us(r_frame_us), .i_wr(w_wr[i]), .i_angle(cfg_angle),
            .o_busy(busy[i]), .o_pwm(pwm[i])
        );
    end

    assign cfg_ready   = r_ready;
    assign frame_start = r_frame_start;
endmodule

// File: tb/tb_servo_pwm_multi.sv
// tb_servo_pwm_multi: jump (step 0) and ramped (step 2) instances checked against a frame-phase behavioural model
`timescale 1ns/1ps
module tb_servo_pwm_multi;
    localparam int CLK_FRE = 2_000_000, PWM_MS = 1, CH = 5;
    localparam int MIN_US = 100, UPD = 3, MAX_A = 180, INIT_A = 90;
    localparam int T = CLK_FRE / 1_000_000;
    localparam int FRAME_CYC = PWM_MS * 1000 * T;

    logic          clk = 1'b0, rst = 1'b1, cfg_valid = 1'b0;
    logic [2:0]    cfg_ch = '0;
    logic [7:0]    cfg_angle = '0;
    logic [1:0]    rdy, fs;
    logic [CH-1:0] busy [2];
    logic [CH-1:0] pwm [2];

    bit ready;
    int phase, checks, errors;
    int cur [2][CH];
    int tgt [2][CH];
    int pw [2][CH];
    int hi [2][CH];
    int step [2] = '{0, 2};

    servo_pwm_multi #(.CLK_FRE(CLK_FRE), .PWM_CYCLE_MS(PWM_MS), .CH_NUM(CH), .MIN_PULSE_US(MIN_US),
        .US_PER_DEG(UPD), .MAX_ANGLE(MAX_A), .INIT_ANGLE(INIT_A), .RAMP_STEP(0)) u_dut0 (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(rdy[0]), .cfg_ch(cfg_ch),
        .cfg_angle(cfg_angle), .frame_start(fs[0]), .busy(busy[0]), .pwm(pwm[0]));

    servo_pwm_multi #(.CLK_FRE(CLK_FRE), .PWM_CYCLE_MS(PWM_MS), .CH_NUM(CH), .MIN_PULSE_US(MIN_US),
        .US_PER_DEG(UPD), .MAX_ANGLE(MAX_A), .INIT_ANGLE(INIT_A), .RAMP_STEP(2)) u_dut2 (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(rdy[1]), .cfg_ch(cfg_ch),
        .cfg_angle(cfg_angle), .frame_start(fs[1]), .busy(busy[1]), .pwm(pwm[1]));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int ramp(input int c, input int t, input int s);
        if (s == 0) return t;
        if (c < t) return c + s < t ? c + s : t;
        return c - s > t ? c - s : t;
    endfunction

    // phase counts cycles since the frame_start cycle; the pulse occupies phases 1..pw*T
    function automatic void model_edge();
        bit acc = !rst && ready && cfg_valid;
        if (rst) begin
            ready = 0;
            phase = 0;
            for (int d = 0; d < 2; d++)
                for (int i = 0; i < CH; i++) begin
                    cur[d][i] = INIT_A;
                    tgt[d][i] = INIT_A;
                    pw[d][i]  = MIN_US + INIT_A * UPD;
                end
        end else if (!ready) begin
            ready = 1;
            phase = 0;
        end else begin
            if (phase == 0)
                for (int d = 0; d < 2; d++)
                    for (int i = 0; i < CH; i++) begin
                        cur[d][i] = ramp(cur[d][i], tgt[d][i], step[d]);
                        pw[d][i]  = MIN_US + cur[d][i] * UPD;
                    end
            phase = (phase + 1) % FRAME_CYC;
        end
        if (acc && int'(cfg_ch) < CH)
            for (int d = 0; d < 2; d++) tgt[d][cfg_ch] = int'(cfg_angle) > MAX_A ? MAX_A : int'(cfg_angle);
    endfunction

    function automatic logic [11:0] exp_vec(input int d);
        logic [CH-1:0] b, p;
        for (int i = 0; i < CH; i++) begin
            b[i] = cur[d][i] != tgt[d][i];
            p[i] = ready && phase >= 1 && phase <= pw[d][i] * T;
        end
        return {ready, ready && phase == 0, b, p};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check(d == 0 ? "cycle_dut0" : "cycle_dut2", 32'({rdy[d], fs[d], busy[d], pwm[d]}), 32'(exp_vec(d)));
            for (int i = 0; i < CH; i++) hi[d][i] += int'(pwm[d][i]);
        end
    endtask

    task automatic write(input int ch, input int ang);
        cfg_valid = 1'b1;
        cfg_ch    = 3'(ch);
        cfg_angle = 8'(ang);
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic run_frame(input bit wr = 0, input int ch = 0, input int ang = 0);
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < CH; i++) hi[d][i] = 0;
        cfg_valid = wr;
        cfg_ch    = 3'(ch);
        cfg_angle = 8'(ang);
        for (int n = 0; n < FRAME_CYC; n++) begin
            tick();
            cfg_valid = 1'b0;
        end
    endtask

    task automatic to_frame_start();
        for (int n = 0; n < FRAME_CYC && !(ready && phase == 0); n++) tick();
        check("frame_align", fs[0], 1);
    endtask

    initial begin
        repeat (3) tick();
        check("rst_out_dut0", 32'({rdy[0], fs[0], busy[0], pwm[0]}), 0);
        check("rst_out_dut2", 32'({rdy[1], fs[1], busy[1], pwm[1]}), 0);
        rst = 1'b0;
        tick();
        check("first_fs", fs[0], 1);
        check("cfg_ready", rdy[1], 1);
        run_frame();
        check("pw90_ch0", hi[0][0], 740);
        check("pw90_ch4", hi[1][4], 740);
        check("busy_idle", busy[0], 0);
        check("fs_period", fs[1], 1);
        tick();
        write(1, 0);
        write(2, 200);
        write(0, 100);
        write(5, 0);
        write(7, 10);
        check("busy_after_wr", busy[1][0], 1);
        to_frame_start();
        run_frame();
        check("jump_ch1", hi[0][1], 200);
        check("clamp_ch2", hi[0][2], 1280);
        check("jump_ch0", hi[0][0], 800);
        check("oob_ch3", hi[0][3], 740);
        check("oob_ch4", hi[1][4], 740);
        check("ramp_92", hi[1][0], 752);
        for (int k = 1; k < 5; k++) begin
            check("ramp_busy", busy[1][0], 1);
            run_frame();
            check("ramp_step", hi[1][0], 752 + 12 * k);
        end
        check("ramp_done", busy[1][0], 0);
        run_frame(1, 3, 0);
        check("fs_wr_same", hi[0][3], 740);
        run_frame();
        check("fs_wr_next", hi[0][3], 200);
        for (int f = 0; f < 20; f++)
            for (int n = 0; n < FRAME_CYC; n++) begin
                if ($urandom_range(0, 39) == 0) begin
                    cfg_valid = 1'b1;
                    cfg_ch    = 3'($urandom_range(0, 7));
                    cfg_angle = 8'($urandom_range(0, 255));
                end
                tick();
                cfg_valid = 1'b0;
            end
        to_frame_start();
        repeat (50) tick();
        check("pre_rst_pwm", pwm[0], 5'h1f);
        rst = 1'b1;
        tick();
        check("rst_pwm_dut0", pwm[0], 0);
        check("rst_pwm_dut2", pwm[1], 0);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        check("rst_first_fs", fs[1], 1);
        run_frame();
        check("rst_angle_dut0", hi[0][2], 740);
        check("rst_angle_dut2", hi[1][1], 740);
        check("rst_busy", busy[1], 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/servo_pwm_multi.md
Name: servo_pwm_multi

Overview:
Parametrised multi-channel hobby-servo PWM generator. It is the successor to the single-channel, key-driven servo driver.
- A host (key decoder, UART or CPU bridge) writes a target angle per channel.
- Each channel slews toward its target by a bounded step once per frame, limiting servo current and mechanical shock.
- All channels share one frame timer. Every pwm output rises at the same frame start.

Parameters:
CLK_FRE, 12_000_000, input clock frequency in Hz
PWM_CYCLE_MS, 20, frame period in ms
CH_NUM, 4, number of servo channels (1..16)
MIN_PULSE_US, 500, pulse width at angle 0
US_PER_DEG, 11, pulse increment per degree (angle 180 gives 2480 us)
MAX_ANGLE, 180, clamp value for target angles
INIT_ANGLE, 90, current and target angle after reset
RAMP_STEP, 2, maximum change in degrees per frame; 0 means jump immediately to target

Ports:
clk, input, 1, system clock
rst, input, 1, synchronous active-high reset
cfg_valid, input, 1, write request
cfg_ready, output, 1, write accepted when cfg_valid and cfg_ready are both high
cfg_ch, input, $clog2(CH_NUM) (minimum 1), channel index
cfg_angle, input, 8, target angle in degrees
frame_start, output, 1, one-cycle pulse on the first cycle of each frame
busy, output, CH_NUM, per channel: current angle differs from target
pwm, output, CH_NUM, servo drive outputs

Behaviour:
- Reset is sampled on the clk edge only, with clk running. While rst is high and on the cycle after it:
  - pwm = 0, frame_start = 0, busy = 0, cfg_ready = 0.
  - All prescaler and frame counters = 0.
  - Every channel's current and target angle = INIT_ANGLE.
- cfg_ready rises on the first cycle after rst falls and then stays high. Writes are accepted in any cycle with no backpressure.
- Timebase:
  - us_cnt counts 0..CLK_FRE/1_000_000-1 and produces a us_tick on its terminal count.
  - frame_us counts 0..PWM_CYCLE_MS*1000-1, advances on us_tick, and wraps to 0.
  - frame_start is registered and high on the cycle in which frame_us becomes 0 and us_cnt = 0. It first asserts one cycle after reset release.
- Write handling:
  - On acceptance, target[cfg_ch] is set to min(cfg_angle, MAX_ANGLE) on the next edge.
  - A write with cfg_ch >= CH_NUM is accepted and discarded.
- Ramp update, on the frame_start cycle, per channel:
  - If current < target: current = min(current+RAMP_STEP, target).
  - If current > target: current = max(current-RAMP_STEP, target).
  - If RAMP_STEP = 0: current = target.
- A write in the same cycle as frame_start does not affect this frame's ramp step. It takes effect at the next frame.
- Shadowing: the pulse width pw_us[i] = MIN_PULSE_US + current[i]*US_PER_DEG is latched at frame start. The pulse never changes within a frame.
- Output: pwm[i] is registered, high while frame_us < pw_us[i], otherwise low.
  - The high time is exactly pw_us*CLK_FRE/1e6 cycles.
  - The rising edge lands one cycle after frame_start.
- busy[i] = (current[i] != target[i]), registered.
- Widths:
  - Angle registers are 8 bits.
  - pw_us and frame_us are sized by $clog2(PWM_CYCLE_MS*1000).
  - The MIN_PULSE_US + MAX_ANGLE*US_PER_DEG term is computed without truncation.
- Elaboration-time errors:
  - MIN_PULSE_US + MAX_ANGLE*US_PER_DEG >= PWM_CYCLE_MS*1000.
  - CLK_FRE not a multiple of 1_000_000.
- Reset mid-pulse: pwm goes low on the next edge and the next frame restarts cleanly from frame_us = 0.

Decomposition:
- Package servo_pkg:
  - US_TICKS, FRAME_US, PW_W and ANG_W localparams derived from the parameters.
  - The pulse-width function pw_of_angle(angle).
  - The clamp function.
- One sub-module, servo_ramp_ch, instantiated CH_NUM times. It contains:
  - the target and current registers;
  - the ramp step logic;
  - the pw_us shadow register;
  - the comparator against the shared frame_us.
- The top level holds the prescaler, frame counter, write decode, and frame_start.

Test Plan:
- Reset release, defaults (12 MHz, 20 ms): frame_start repeats every 240000 cycles. Every pwm is high for 17880 cycles (90 degrees = 1490 us). busy = 0.
- With RAMP_STEP = 0, write ch1 angle 0: from the next frame pwm[1] is high for exactly 6000 cycles. Other channels remain at 17880.
- Write ch2 angle 200: target is clamped to 180. With RAMP_STEP = 0, pwm[2] is high for 29760 cycles.
- With RAMP_STEP = 2, write ch0 angle 100:
  - busy[0] = 1.
  - Successive frames show 92, 94, 96, 98, 100 degrees (pulse width increasing by 264 cycles per frame).
  - busy[0] falls after the fifth update.
- Write issued in the same cycle as frame_start: the current frame's ramp ignores it and the change appears one frame later. A write with cfg_ch = 5 when CH_NUM = 4 changes nothing.
- Assert rst for 3 cycles midway through a pwm high phase: pwm is 0 the next cycle, angles return to 90, and the first frame_start comes one cycle after rst falls.
